// File: rtl/cu_responder.sv
// cu_responder: control-unit end of a bus-and-tag channel interface.
//
// The unit answers initial selection for ADDRESS, latches a command byte,
// presents initial status, moves data bytes with service_in/service_out,
// presents ending status and then releases the interface. A selection for
// another address is passed to the next unit on the select chain.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   b_*                     channel cable side (bus_out/bus_in plus tags)
//   a_select_out/in         select chain towards the next unit
//   busy                    device busy, answered with status 8'h10
//   command, command_valid  latched command byte, pulse for data commands
//   data_recv_*             write-data stream to the device (one-byte skid)
//   data_send_*             read-data stream from the device
//   data_end                device has no more data (level)
//
// Build option
//   PARITY_CHECK_EN  check odd parity of bus_out on address, command and
//                    write-data bytes. Undefined: parity input is ignored.
module cu_responder #(
    parameter logic [7:0] ADDRESS = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] b_bus_out,
    input  logic       b_bus_out_parity,
    output logic [7:0] b_bus_in,
    output logic       b_bus_in_parity,
    input  logic       b_operational_out,
    input  logic       b_hold_out,
    input  logic       b_select_out,
    output logic       b_select_in,
    input  logic       b_address_out,
    input  logic       b_command_out,
    input  logic       b_service_out,
    input  logic       b_suppress_out,
    output logic       b_operational_in,
    output logic       b_address_in,
    output logic       b_status_in,
    output logic       b_service_in,
    output logic       b_request_in,
    output logic       a_select_out,
    input  logic       a_select_in,
    input  logic       busy,
    output logic [7:0] command,
    output logic       command_valid,
    output logic [7:0] data_recv_tdata,
    output logic       data_recv_tvalid,
    input  logic       data_recv_tready,
    input  logic [7:0] data_send_tdata,
    input  logic       data_send_tvalid,
    output logic       data_send_tready,
    input  logic       data_end
);

    typedef enum logic [2:0] {IDLE, PASS, ADDR, CMD, ISTAT, DATA, ESTAT, REL} state_t;

    state_t     state, state_n;
    logic [7:0] bus_out_p0;
    logic       oper_p0, hold_p0, sel_p0, addr_p0, cmd_p0, svc_p0, a_sel_p0;
    logic       par_ok;

    // stage p0: every cable input is registered once
    always_ff @(posedge clk) begin
        bus_out_p0 <= b_bus_out;
        if (reset) begin
            oper_p0  <= 1'b0;
            hold_p0  <= 1'b0;
            sel_p0   <= 1'b0;
            addr_p0  <= 1'b0;
            cmd_p0   <= 1'b0;
            svc_p0   <= 1'b0;
            a_sel_p0 <= 1'b0;
        end else begin
            oper_p0  <= b_operational_out;
            hold_p0  <= b_hold_out;
            sel_p0   <= b_select_out;
            addr_p0  <= b_address_out;
            cmd_p0   <= b_command_out;
            svc_p0   <= b_service_out;
            a_sel_p0 <= a_select_in;
        end
    end

`ifdef PARITY_CHECK_EN
    logic bus_par_p0;
    logic unused_in;
    always_ff @(posedge clk) bus_par_p0 <= b_bus_out_parity;
    // odd parity: the nine bits together carry an odd number of ones
    assign par_ok    = ^{bus_out_p0, bus_par_p0};
    assign unused_in = b_suppress_out;
`else
    logic unused_in;
    assign par_ok    = 1'b1;
    assign unused_in = ^{b_suppress_out, b_bus_out_parity};
`endif

    // transfer context: direction, write-handshake phase, error flags
    logic       rd, wr, wait_low, derr, cerr;
    logic       rd_n, wr_n, wait_low_n, derr_n, cerr_n;
    logic [7:0] bus_in_n, command_n, recv_data_n;
    logic       op_in_n, addr_in_n, stat_in_n, svc_in_n, sel_in_n, a_sel_n;
    logic       cmd_valid_n, recv_valid_n, send_ready_n;
    logic       recv_full;

    assign recv_full       = data_recv_tvalid && !data_recv_tready;
    assign b_bus_in_parity = ~^b_bus_in;
    assign b_request_in    = 1'b0;

    always_comb begin
        state_n      = state;
        bus_in_n     = b_bus_in;
        op_in_n      = b_operational_in;
        addr_in_n    = b_address_in;
        stat_in_n    = b_status_in;
        svc_in_n     = b_service_in;
        sel_in_n     = 1'b0;
        a_sel_n      = 1'b0;
        command_n    = command;
        cmd_valid_n  = 1'b0;
        recv_data_n  = data_recv_tdata;
        recv_valid_n = recv_full;
        send_ready_n = 1'b0;
        rd_n         = rd;
        wr_n         = wr;
        wait_low_n   = wait_low;
        derr_n       = derr;
        cerr_n       = cerr;

        if (!oper_p0) begin
            state_n   = IDLE;
            bus_in_n  = 8'h00;
            op_in_n   = 1'b0;
            addr_in_n = 1'b0;
            stat_in_n = 1'b0;
            svc_in_n  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (addr_p0 && sel_p0) begin
                        if (hold_p0 && bus_out_p0 == ADDRESS && par_ok) begin
                            state_n   = ADDR;
                            op_in_n   = 1'b1;
                            addr_in_n = 1'b1;
                            bus_in_n  = ADDRESS;
                        end else begin
                            state_n = PASS;
                            a_sel_n = 1'b1;
                        end
                    end
                end
                PASS: begin
                    if (!sel_p0) begin
                        state_n = IDLE;
                    end else begin
                        a_sel_n  = 1'b1;
                        sel_in_n = a_sel_p0;
                    end
                end
                ADDR: begin
                    if (!addr_p0 && cmd_p0) begin
                        state_n   = CMD;
                        command_n = bus_out_p0;
                        cerr_n    = !par_ok;
                        addr_in_n = 1'b0;
                        bus_in_n  = 8'h00;
                        rd_n      = 1'b0;
                        wr_n      = 1'b0;
                        derr_n    = 1'b0;
                    end
                end
                CMD: begin
                    if (!cmd_p0) begin
                        state_n   = ISTAT;
                        stat_in_n = 1'b1;
                        if (busy)
                            bus_in_n = 8'h10;
                        else if (cerr)
                            bus_in_n = 8'h02;
                        else begin
                            case (command)
                                8'h01: begin bus_in_n = 8'h00; wr_n = 1'b1; cmd_valid_n = 1'b1; end
                                8'h02: begin bus_in_n = 8'h00; rd_n = 1'b1; cmd_valid_n = 1'b1; end
                                8'h03: bus_in_n = 8'h0C;
                                default: bus_in_n = 8'h02;
                            endcase
                        end
                    end
                end
                ISTAT: begin
                    if (b_status_in && svc_p0) begin
                        stat_in_n = 1'b0;
                        if (rd || wr)
                            bus_in_n = 8'h00;
                        else
                            state_n = REL;
                    end else if (!b_status_in && !svc_p0) begin
                        state_n    = DATA;
                        wait_low_n = 1'b0;
                    end
                end
                DATA: begin
                    if (b_service_in) begin
                        if (cmd_p0) begin
                            // channel stop: the offered byte is not counted
                            state_n  = ESTAT;
                            svc_in_n = 1'b0;
                            bus_in_n = 8'h00;
                        end else if (svc_p0) begin
                            svc_in_n   = 1'b0;
                            bus_in_n   = 8'h00;
                            wait_low_n = 1'b1;
                            if (rd)
                                send_ready_n = 1'b1;  // byte is consumed only once accepted
                            else if (par_ok) begin
                                recv_data_n  = bus_out_p0;
                                recv_valid_n = 1'b1;
                            end else
                                derr_n = 1'b1;
                        end
                    end else if (wait_low) begin
                        if (!svc_p0)
                            wait_low_n = 1'b0;
                    end else if (data_end) begin
                        state_n = ESTAT;
                    end else if (rd) begin
                        if (data_send_tvalid) begin
                            svc_in_n = 1'b1;
                            bus_in_n = data_send_tdata;
                        end
                    end else if (!recv_full) begin
                        svc_in_n = 1'b1;
                        bus_in_n = 8'h00;
                    end
                end
                ESTAT: begin
                    if (!b_status_in) begin
                        if (!cmd_p0 && !svc_p0) begin
                            stat_in_n = 1'b1;
                            bus_in_n  = derr ? 8'h0E : 8'h0C;
                        end
                    end else if (svc_p0) begin
                        stat_in_n = 1'b0;
                        state_n   = REL;
                    end
                end
                REL: begin
                    if (!svc_p0) begin
                        state_n  = IDLE;
                        op_in_n  = 1'b0;
                        bus_in_n = 8'h00;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // stage p1: registered outputs and state
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            b_bus_in         <= 8'h00;
            b_operational_in <= 1'b0;
            b_address_in     <= 1'b0;
            b_status_in      <= 1'b0;
            b_service_in     <= 1'b0;
            b_select_in      <= 1'b0;
            a_select_out     <= 1'b0;
            command          <= 8'h00;
            command_valid    <= 1'b0;
            data_recv_tdata  <= 8'h00;
            data_recv_tvalid <= 1'b0;
            data_send_tready <= 1'b0;
            rd               <= 1'b0;
            wr               <= 1'b0;
            wait_low         <= 1'b0;
            derr             <= 1'b0;
            cerr             <= 1'b0;
        end else begin
            state            <= state_n;
            b_bus_in         <= bus_in_n;
            b_operational_in <= op_in_n;
            b_address_in     <= addr_in_n;
            b_status_in      <= stat_in_n;
            b_service_in     <= svc_in_n;
            b_select_in      <= sel_in_n;
            a_select_out     <= a_sel_n;
            command          <= command_n;
            command_valid    <= cmd_valid_n;
            data_recv_tdata  <= recv_data_n;
            data_recv_tvalid <= recv_valid_n;
            data_send_tready <= send_ready_n;
            rd               <= rd_n;
            wr               <= wr_n;
            wait_low         <= wait_low_n;
            derr             <= derr_n;
            cerr             <= cerr_n;
        end
    end

endmodule

// File: tb/tb_cu_responder.sv
module tb_cu_responder;
    localparam logic [7:0] DEV = 8'h1a;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [7:0] b_bus_out;
    logic       b_bus_out_parity;
    logic [7:0] b_bus_in;
    logic       b_bus_in_parity;
    logic       b_operational_out, b_hold_out, b_select_out, b_select_in;
    logic       b_address_out, b_command_out, b_service_out, b_suppress_out;
    logic       b_operational_in, b_address_in, b_status_in, b_service_in, b_request_in;
    logic       a_select_out, a_select_in, busy;
    logic [7:0] command;
    logic       command_valid;
    logic [7:0] data_recv_tdata;
    logic       data_recv_tvalid, data_recv_tready;
    logic [7:0] data_send_tdata;
    logic       data_send_tvalid, data_send_tready, data_end;

    cu_responder #(.ADDRESS(DEV)) dut (
        .clk(clk), .reset(reset),
        .b_bus_out(b_bus_out), .b_bus_out_parity(b_bus_out_parity),
        .b_bus_in(b_bus_in), .b_bus_in_parity(b_bus_in_parity),
        .b_operational_out(b_operational_out), .b_hold_out(b_hold_out),
        .b_select_out(b_select_out), .b_select_in(b_select_in),
        .b_address_out(b_address_out), .b_command_out(b_command_out),
        .b_service_out(b_service_out), .b_suppress_out(b_suppress_out),
        .b_operational_in(b_operational_in), .b_address_in(b_address_in),
        .b_status_in(b_status_in), .b_service_in(b_service_in),
        .b_request_in(b_request_in),
        .a_select_out(a_select_out), .a_select_in(a_select_in),
        .busy(busy), .command(command), .command_valid(command_valid),
        .data_recv_tdata(data_recv_tdata), .data_recv_tvalid(data_recv_tvalid),
        .data_recv_tready(data_recv_tready),
        .data_send_tdata(data_send_tdata), .data_send_tvalid(data_send_tvalid),
        .data_send_tready(data_send_tready), .data_end(data_end)
    );

    int total = 0;
    int bad   = 0;

    // device model: read source, write sink, command_valid counter
    logic [7:0]  send_mem [16];
    logic [7:0]  wdata    [16];
    logic [7:0]  recv_log [64];
    logic [31:0] send_cnt = 0, send_base = 0, send_avail = 0;
    logic [31:0] recv_cnt = 0, recv_base = 0, end_after = 0;
    logic        end_en = 1'b0;
    int          cv_cnt = 0;
    logic [31:0] send_off;

    assign send_off         = send_cnt - send_base;
    assign data_send_tvalid = send_off < send_avail;
    assign data_send_tdata  = send_mem[send_off[3:0]];
    assign data_end         = end_en && ((recv_cnt - recv_base) >= end_after);

    always @(posedge clk) begin
        if (data_send_tready && data_send_tvalid) send_cnt <= send_cnt + 1;
        if (data_recv_tvalid && data_recv_tready) begin
            recv_log[recv_cnt[5:0]] <= data_recv_tdata;
            recv_cnt <= recv_cnt + 1;
        end
    end
    always @(negedge clk) if (command_valid) cv_cnt <= cv_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic outsig(input int w);
        case (w)
            0: return b_operational_in;
            1: return b_address_in;
            2: return b_status_in;
            default: return b_service_in;
        endcase
    endfunction

    task automatic wait_out(input int w, input logic v, input string tag);
        int n = 0;
        while (outsig(w) !== v && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (outsig(w) !== v) chk(tag, {31'd0, outsig(w)}, {31'd0, v});
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_op"},   b_operational_in, 0);
        chk({tag, "_adr"},  b_address_in, 0);
        chk({tag, "_st"},   b_status_in, 0);
        chk({tag, "_svc"},  b_service_in, 0);
        chk({tag, "_bus"},  b_bus_in, 8'h00);
        chk({tag, "_cmd"},  command, 8'h00);
        chk({tag, "_asel"}, a_select_out, 0);
        chk({tag, "_bsel"}, b_select_in, 0);
        chk({tag, "_rdy"},  data_send_tready, 0);
        chk({tag, "_rvld"}, data_recv_tvalid, 0);
        chk({tag, "_cv"},   command_valid, 0);
    endtask

    task automatic put_bus(input logic [7:0] v);
        b_bus_out        = v;
        b_bus_out_parity = ~^v;
    endtask

    // initial selection, command and initial status
    task automatic select_dev(input logic [7:0] cmd, input logic [7:0] exp_stat);
        @(negedge clk);
        put_bus(DEV);
        b_address_out = 1'b1; b_hold_out = 1'b1; b_select_out = 1'b1;
        wait_out(1, 1'b1, "addr_in_rise");
        chk("addr_bus", b_bus_in, DEV);
        chk("addr_op", b_operational_in, 1'b1);
        b_address_out = 1'b0; put_bus(cmd); b_command_out = 1'b1;
        wait_out(1, 1'b0, "addr_in_fall");
        b_command_out = 1'b0; b_select_out = 1'b0; b_hold_out = 1'b0;
        wait_out(2, 1'b1, "istat_rise");
        chk("cmd_latch", command, cmd);
        chk("istat_val", b_bus_in, exp_stat);
        b_service_out = 1'b1;
        wait_out(2, 1'b0, "istat_fall");
        b_service_out = 1'b0;
    endtask

    task automatic end_status(input logic [7:0] exp_stat);
        wait_out(2, 1'b1, "estat_rise");
        chk("estat_val", b_bus_in, exp_stat);
        b_service_out = 1'b1;
        wait_out(2, 1'b0, "estat_fall");
        b_service_out = 1'b0;
        wait_out(0, 1'b0, "release");
        chk("rel_bus", b_bus_in, 8'h00);
    endtask

    initial begin
        int cv0, nwr, n;
        logic done;
        reset = 1'b1;
        b_operational_out = 1'b0; b_hold_out = 1'b0; b_select_out = 1'b0;
        b_address_out = 1'b0; b_command_out = 1'b0; b_service_out = 1'b0;
        b_suppress_out = 1'b0; a_select_in = 1'b0; busy = 1'b0;
        data_recv_tready = 1'b1;
        put_bus(8'h00);
        for (int i = 0; i < 16; i++) begin
            send_mem[i] = 8'(8'h5a + i * 8'h13);
            wdata[i]    = 8'(8'hc3 ^ (i * 8'h25));
        end
        repeat (3) @(negedge clk);
        chk_idle("rst");
        chk("rst_par", b_bus_in_parity, 1'b1);
        chk("req_in", b_request_in, 1'b0);
        reset = 1'b0;
        b_operational_out = 1'b1;
        repeat (2) @(negedge clk);

        // non-matching address is passed down the select chain
        put_bus(8'h10);
        b_address_out = 1'b1; b_hold_out = 1'b1; b_select_out = 1'b1;
        repeat (3) @(negedge clk);
        chk("pass_asel", a_select_out, 1'b1);
        chk("pass_bsel0", b_select_in, 1'b0);
        a_select_in = 1'b1;
        repeat (3) @(negedge clk);
        chk("pass_bsel1", b_select_in, 1'b1);
        chk("pass_op", b_operational_in, 1'b0);
        chk("pass_adr", b_address_in, 1'b0);
        b_select_out = 1'b0; b_address_out = 1'b0; b_hold_out = 1'b0; a_select_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("pass_end_asel", a_select_out, 1'b0);
        chk("pass_end_bsel", b_select_in, 1'b0);

        // busy device: status 8'h10, no command_valid
        busy = 1'b1;
        cv0 = cv_cnt;
        select_dev(8'h02, 8'h10);
        wait_out(0, 1'b0, "busy_rel");
        chk("busy_cv", cv_cnt - cv0, 0);
        busy = 1'b0;
        repeat (2) @(negedge clk);

        // READ: device has 16 bytes, channel takes 6 then stops
        send_base = send_cnt; send_avail = 16;
        cv0 = cv_cnt;
        select_dev(8'h02, 8'h00);
        chk("rd_cv", cv_cnt - cv0, 1);
        for (int i = 0; i < 6; i++) begin
            wait_out(3, 1'b1, "rd_svc_rise");
            chk($sformatf("rd_byte%0d", i), b_bus_in, send_mem[i]);
            chk($sformatf("rd_par%0d", i), b_bus_in_parity, ~^send_mem[i]);
            b_service_out = 1'b1;
            wait_out(3, 1'b0, "rd_svc_fall");
            b_service_out = 1'b0;
        end
        wait_out(3, 1'b1, "rd_stop_rise");
        b_command_out = 1'b1;
        wait_out(3, 1'b0, "rd_stop_fall");
        b_command_out = 1'b0;
        end_status(8'h0C);
        chk("rd_consumed", send_cnt - send_base, 6);
        send_avail = 0;
        repeat (2) @(negedge clk);

        // WRITE: device ends after 6 bytes, channel would send 16
        recv_base = recv_cnt; end_after = 6; end_en = 1'b1;
        cv0 = cv_cnt;
        select_dev(8'h01, 8'h00);
        chk("wr_cv", cv_cnt - cv0, 1);
        nwr = 0; done = 1'b0;
        for (int i = 0; i < 16 && !done; i++) begin
            n = 0;
            while (!b_service_in && !b_status_in && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (b_status_in || n >= 200) done = 1'b1;
            else begin
                chk("wr_bus_zero", b_bus_in, 8'h00);
                put_bus(wdata[i]);
                b_service_out = 1'b1;
                wait_out(3, 1'b0, "wr_svc_fall");
                b_service_out = 1'b0;
                nwr++;
            end
        end
        chk("wr_count", nwr, 6);
        end_status(8'h0C);
        for (int i = 0; i < 6; i++) begin
            logic [31:0] k;
            k = recv_base + i;
            chk($sformatf("wr_recv%0d", i), recv_log[k[5:0]], wdata[i]);
        end
        chk("wr_recv_cnt", recv_cnt - recv_base, 6);
        end_en = 1'b0;
        repeat (2) @(negedge clk);

        // NOP and an unknown command
        select_dev(8'h03, 8'h0C);
        wait_out(0, 1'b0, "nop_rel");
        repeat (2) @(negedge clk);
        select_dev(8'hff, 8'h02);
        wait_out(0, 1'b0, "bad_rel");
        chk("bad_svc", b_service_in, 1'b0);
        repeat (2) @(negedge clk);

        // reset in the middle of a READ, then a fresh selection
        send_base = send_cnt; send_avail = 16;
        select_dev(8'h02, 8'h00);
        for (int i = 0; i < 2; i++) begin
            wait_out(3, 1'b1, "rr_svc_rise");
            b_service_out = 1'b1;
            wait_out(3, 1'b0, "rr_svc_fall");
            b_service_out = 1'b0;
        end
        wait_out(3, 1'b1, "rr_third");
        reset = 1'b1;
        @(negedge clk);
        chk_idle("mid_rst");
        reset = 1'b0;
        send_avail = 0;
        repeat (2) @(negedge clk);
        select_dev(8'h03, 8'h0C);
        wait_out(0, 1'b0, "post_rst_rel");
        chk("post_rst_bus", b_bus_in, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cu_responder.md
Name: cu_responder

Overview:
- Synthesizable control-unit end of the bus-and-tag channel interface; the responder counterpart to the `channel` initiator.
- Recognises its device address during initial selection, accepts a command byte and presents initial status.
- Moves data bytes with service_in/service_out, presents ending status, then releases the interface.
- Non-matching selection is propagated downstream. Sits between the channel's b_ cable side and the local device logic.

Parameters:
- ADDRESS, 8'h00, device address this unit answers to.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- b_bus_out  in  8  byte from channel
- b_bus_out_parity  in  1  odd parity of b_bus_out
- b_bus_in  out  8  byte to channel
- b_bus_in_parity  out  1  odd parity of b_bus_in
- b_operational_out  in  1  channel operational
- b_hold_out  in  1  selection hold
- b_select_out  in  1  selection from channel
- b_select_in  out  1  selection returned to channel
- b_address_out  in  1  address valid on bus_out
- b_command_out  in  1  command valid / stop
- b_service_out  in  1  channel accepts/supplies byte
- b_suppress_out  in  1  ignored (no status stacking)
- b_operational_in  out  1  unit selected
- b_address_in  out  1  address on bus_in
- b_status_in  out  1  status on bus_in
- b_service_in  out  1  data service request
- b_request_in  out  1  tied 0
- a_select_out  out  1  selection to next unit
- a_select_in  in  1  selection returned from next unit
- busy  in  1  device busy
- command  out  8  latched command byte
- command_valid  out  1  one-cycle pulse when command accepted
- data_recv_tdata  out  8  write-data byte to device
- data_recv_tvalid  out  1  write-data valid
- data_recv_tready  in  1  device accepts byte
- data_send_tdata  in  8  read-data byte from device
- data_send_tvalid  in  1  read-data valid
- data_send_tready  out  1  byte taken
- data_end  in  1  device has no more data (level)

Behaviour:
- All b_/a_ inputs are registered once; every output is registered. Each response appears 1 clk after the sampled input edge.
- Reset: all outputs 0, command=8'h00, state IDLE. Reset mid-transfer drops every tag in the next cycle.
- b_operational_out low in any state -> IDLE, all tags low.
- b_select_in = a_select_in whenever in PASS, else 0. a_select_out = b_select_out while in PASS.
- IDLE:
  - b_address_out && b_select_out && b_hold_out && b_bus_out==ADDRESS -> raise operational_in, go ADDR.
  - Non-matching address with select_out -> PASS.
- PASS -> IDLE when select_out drops.
- ADDR:
  - Drive bus_in=ADDRESS and raise address_in.
  - Wait !address_out && command_out; latch bus_out into command; drop address_in -> CMD.
- CMD:
  - Wait command_out low, then classify and present initial status (drive bus_in, raise status_in):
    - busy -> 8'h10
    - 01 WRITE / 02 READ -> 8'h00, pulse command_valid
    - 03 NOP -> 8'h0C
    - other -> 8'h02 (unit check)
  - -> ISTAT.
- ISTAT:
  - On service_out, drop status_in.
  - Data commands -> DATA once service_out falls; otherwise -> REL.
- DATA:
  - WRITE: raise service_in with bus_in=0. On service_out, capture bus_out into the recv skid register.
  - READ: take one send byte (data_send_tready 1 cycle), raise service_in with the byte. Complete on service_out.
  - After service_out falls, next byte. Max one byte in flight.
  - command_out answering service_in = channel stop: drop service_in, byte not counted -> ESTAT.
  - data_end high with no byte in flight -> ESTAT.
  - WRITE stalls while recv skid is full (data_recv_tvalid && !tready).
- ESTAT:
  - bus_in=8'h0C (channel end + device end), status_in.
  - On service_out drop status_in -> REL.
- REL: drop operational_in and bus_in when service_out is low -> IDLE.
- b_bus_in_parity = ~^b_bus_in always.

Optional Feature:
- PARITY_CHECK_EN defined: bus_out parity is checked when address_out or command_out is sampled and on each WRITE byte.
  - Error on address: no selection (PASS).
  - Error on command: initial status 8'h02.
  - Error on data: byte dropped, ending status 8'h0E.
- Undefined: parity input ignored, no check logic.

Test Plan:
- Address 8'h10 vs ADDRESS=8'h1a -> a_select_out follows select_out, b_select_in echoes a_select_in, operational_in never raised.
- Address 8'h1a, busy=1, command 02 -> address_in with 8'h1a, status 8'h10, operational_in drops, no command_valid.
- READ, device supplies 16 bytes, channel count 6 -> 6 service_in cycles, command_out stop, ending status 8'h0C, device bytes consumed = 6.
- WRITE, data_end after 6 bytes, channel count 16 -> 6 bytes on data_recv in order, ending status 8'h0C.
- NOP -> initial status 8'h0C, no data; command 8'hff -> initial status 8'h02; both return to IDLE.
- Reset asserted during READ DATA -> next cycle all outputs 0; new selection then completes normally.
